cr_prefix_rec_mac_act: RTL and testbench

//  Per-neuron multiply-accumulate and activation stage of the prefix recognizer.

---
 rtl/cr_prefix_rec_mac_act_pkg.sv | 22 ++
 rtl/cr_prefix_rec_mac_lane.sv | 172 +++++++++++++++++
 rtl/cr_prefix_rec_mac_act.sv | 98 +++++++++
 tb/tb_cr_prefix_rec_mac_act.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cr_prefix_rec_mac_act_pkg.sv
// Shared types and widths for the prefix recognizer MAC/activation stage.
package cr_prefix_rec_mac_act_pkg;

  localparam int REC_ACC_W  = 20;
  localparam int REC_PROD_W = 17;

  typedef enum logic [1:0] {
    ACT_ID     = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_RELU64 = 2'b10,
    ACT_STEP   = 2'b11
  } act_fn_e;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       act;
    act_fn_e    fn;
    logic [3:0] shift;
  } rec_ctrl_t;

endpackage

// File: rtl/cr_prefix_rec_mac_lane.sv
// One neuron lane: S1 signed multiply, S2 saturating accumulate with sticky
// overflow, S3 rounding shift plus activation into the result register.
module cr_prefix_rec_mac_lane
  import cr_prefix_rec_mac_act_pkg::*;
#(
  parameter int NW    = 8,
  parameter int ACC_W = REC_ACC_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          halt,
  input  logic [NW-1:0] coeff,
  input  logic [NW-1:0] neuron,
  input  logic          neuron_sign,
  input  logic          prod_en,
  input  logic          prod_clr,
  input  logic          acc_act,
  input  act_fn_e       acc_fn,
  input  logic [3:0]    acc_shift,
  output logic [NW-1:0] result,
  output logic          ovf
);

  localparam int PROD_W = 2 * NW + 1;

  localparam logic [ACC_W-1:0] ACC_MAX_C = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN_C = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic signed [ACC_W:0] RES_MAX_C = {{(ACC_W+2-NW){1'b0}}, {(NW-1){1'b1}}};
  localparam logic signed [ACC_W:0] RES_MIN_C = {{(ACC_W+2-NW){1'b1}}, {(NW-1){1'b0}}};
  localparam logic signed [ACC_W:0] R64_C     = {{(ACC_W+2-NW){1'b0}}, 1'b1, {(NW-2){1'b0}}};
  localparam logic signed [ACC_W:0] ZERO_C    = {(ACC_W+1){1'b0}};

  logic [PROD_W-1:0]       c_ext_s;
  logic [PROD_W-1:0]       op_ext_s;
  logic [PROD_W-1:0]       prod_s;
  logic [PROD_W-1:0]       prod_r;
  logic [ACC_W-1:0]        acc_r;
  logic [ACC_W-1:0]        acc_nxt_s;
  logic                    ovf_r;
  logic                    ovf_nxt_s;
  logic signed [ACC_W:0]   prod_ext_s;
  logic signed [ACC_W:0]   acc_ext_s;
  logic signed [ACC_W:0]   sum_s;
  logic                    sat_s;
  logic signed [ACC_W:0]   rnd_s;
  logic signed [ACC_W:0]   shifted_s;
  logic [NW-1:0]           act_s;
  logic [NW-1:0]           result_r;

  // S1: operands extended to the product width; low bits of the product are exact
  always_comb begin
    c_ext_s  = {{(NW+1){coeff[NW-1]}}, coeff};
    op_ext_s = '0;
    if (neuron_sign) begin
      op_ext_s = {{(NW+1){neuron[NW-1]}}, neuron};
    end else begin
      op_ext_s = {{(NW+1){1'b0}}, neuron};
    end
    prod_s = c_ext_s * op_ext_s;
  end

  // S2: clear/load/accumulate with saturation and sticky overflow
  always_comb begin
    prod_ext_s = {{(ACC_W+1-PROD_W){prod_r[PROD_W-1]}}, prod_r};
    acc_ext_s  = {acc_r[ACC_W-1], acc_r};
    sum_s      = acc_ext_s + prod_ext_s;
    sat_s      = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    acc_nxt_s  = acc_r;
    ovf_nxt_s  = ovf_r;
    case ({prod_clr, prod_en})
      2'b11: begin
        acc_nxt_s = prod_ext_s[ACC_W-1:0];
        ovf_nxt_s = 1'b0;
      end
      2'b10: begin
        acc_nxt_s = '0;
        ovf_nxt_s = 1'b0;
      end
      2'b01: begin
        if (sat_s) begin
          acc_nxt_s = sum_s[ACC_W] ? ACC_MIN_C : ACC_MAX_C;
          ovf_nxt_s = 1'b1;
        end else begin
          acc_nxt_s = sum_s[ACC_W-1:0];
          ovf_nxt_s = ovf_r;
        end
      end
      default: begin
        acc_nxt_s = acc_r;
        ovf_nxt_s = ovf_r;
      end
    endcase
  end

  // S3: round-half-up arithmetic shift at ACC_W+1 bits, then activation clamp
  always_comb begin
    rnd_s     = '0;
    shifted_s = acc_ext_s;
    if (acc_shift == 4'd0) begin
      shifted_s = acc_ext_s;
    end else begin
      rnd_s     = {{ACC_W{1'b0}}, 1'b1} << (acc_shift - 4'd1);
      shifted_s = (acc_ext_s + rnd_s) >>> acc_shift;
    end
    act_s = '0;
    case (acc_fn)
      ACT_ID: begin
        if (shifted_s > RES_MAX_C) begin
          act_s = RES_MAX_C[NW-1:0];
        end else if (shifted_s < RES_MIN_C) begin
          act_s = RES_MIN_C[NW-1:0];
        end else begin
          act_s = shifted_s[NW-1:0];
        end
      end
      ACT_RELU: begin
        if (shifted_s > RES_MAX_C) begin
          act_s = RES_MAX_C[NW-1:0];
        end else if (shifted_s < ZERO_C) begin
          act_s = '0;
        end else begin
          act_s = shifted_s[NW-1:0];
        end
      end
      ACT_RELU64: begin
        if (shifted_s > R64_C) begin
          act_s = R64_C[NW-1:0];
        end else if (shifted_s < ZERO_C) begin
          act_s = '0;
        end else begin
          act_s = shifted_s[NW-1:0];
        end
      end
      ACT_STEP: begin
        if (shifted_s > ZERO_C) begin
          act_s = {{(NW-1){1'b0}}, 1'b1};
        end else begin
          act_s = '0;
        end
      end
      default: act_s = '0;
    endcase
  end

  // Lane state: halt flushes, hold freezes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r   <= '0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else if (halt) begin
      prod_r   <= '0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else if (!hold) begin
      prod_r <= prod_s;
      acc_r  <= acc_nxt_s;
      ovf_r  <= ovf_nxt_s;
      if (acc_act) begin
        result_r <= act_s;
      end
    end
  end

  assign result = result_r;
  assign ovf    = ovf_r;

endmodule

// File: rtl/cr_prefix_rec_mac_act.sv
// Prefix recognizer MAC/activation stage: shared control pipe, lane array
// and the registered overflow summary.
module cr_prefix_rec_mac_act
  import cr_prefix_rec_mac_act_pkg::*;
#(
  parameter int N_NEURONS = 128,
  parameter int NW        = 8,
  parameter int ACC_W     = REC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_NEURONS*NW-1:0] rec_di_coeff,
  input  logic [N_NEURONS*NW-1:0] rec_di_neuron,
  input  logic                    rec_di_neuron_sign,
  input  logic                    rec_us_hold,
  input  logic                    rec_us_halt,
  input  logic                    rec_us_acc_en,
  input  logic                    rec_us_acc_clr,
  input  logic                    rec_us_act,
  input  logic [1:0]              rec_us_act_fn,
  input  logic [3:0]              rec_us_act_shift,
  output logic [N_NEURONS*NW-1:0] rec_act_result,
  output logic                    rec_act_valid,
  output logic                    rec_act_ovf
);

  rec_ctrl_t            beat_ctrl_s;
  rec_ctrl_t            s1_ctrl_r;
  logic                 s2_act_r;
  act_fn_e              s2_fn_r;
  logic [3:0]           s2_shift_r;
  logic                 valid_r;
  logic                 ovf_r;
  logic [N_NEURONS-1:0] lane_ovf_s;

  // Bundle the beat controls so they travel alongside the data
  always_comb begin
    beat_ctrl_s.en    = rec_us_acc_en;
    beat_ctrl_s.clr   = rec_us_acc_clr;
    beat_ctrl_s.act   = rec_us_act;
    beat_ctrl_s.fn    = act_fn_e'(rec_us_act_fn);
    beat_ctrl_s.shift = rec_us_act_shift;
  end

  // Control pipe; valid drops during hold so a pending act fires after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctrl_r  <= '0;
      s2_act_r   <= 1'b0;
      s2_fn_r    <= ACT_ID;
      s2_shift_r <= 4'd0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (rec_us_halt) begin
      s1_ctrl_r  <= '0;
      s2_act_r   <= 1'b0;
      s2_fn_r    <= ACT_ID;
      s2_shift_r <= 4'd0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (rec_us_hold) begin
      valid_r <= 1'b0;
    end else begin
      s1_ctrl_r  <= beat_ctrl_s;
      s2_act_r   <= s1_ctrl_r.act;
      s2_fn_r    <= s1_ctrl_r.fn;
      s2_shift_r <= s1_ctrl_r.shift;
      valid_r    <= s2_act_r;
      ovf_r      <= |lane_ovf_s;
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
    cr_prefix_rec_mac_lane #(
      .NW    (NW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (rec_us_hold),
      .halt        (rec_us_halt),
      .coeff       (rec_di_coeff[g*NW +: NW]),
      .neuron      (rec_di_neuron[g*NW +: NW]),
      .neuron_sign (rec_di_neuron_sign),
      .prod_en     (s1_ctrl_r.en),
      .prod_clr    (s1_ctrl_r.clr),
      .acc_act     (s2_act_r),
      .acc_fn      (s2_fn_r),
      .acc_shift   (s2_shift_r),
      .result      (rec_act_result[g*NW +: NW]),
      .ovf         (lane_ovf_s[g])
    );
  end

  assign rec_act_valid = valid_r;
  assign rec_act_ovf   = ovf_r;

endmodule

// File: tb/tb_cr_prefix_rec_mac_act.sv
// Scoreboard bench for cr_prefix_rec_mac_act: directed beats push expected
// results; a negedge monitor pops and compares on every valid pulse.
module tb_cr_prefix_rec_mac_act;
  localparam int N  = 128;
  localparam int NW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*NW-1:0] coeff, neuron, result;
  logic            sgn, hold, halt, en, clr, act, valid, ovf;
  logic [1:0]      fn;
  logic [3:0]      sh;

  typedef struct {
    logic [N*NW-1:0] res;
    logic            ovf;
    int              at;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  cr_prefix_rec_mac_act dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rec_di_coeff       (coeff),
    .rec_di_neuron      (neuron),
    .rec_di_neuron_sign (sgn),
    .rec_us_hold        (hold),
    .rec_us_halt        (halt),
    .rec_us_acc_en      (en),
    .rec_us_acc_clr     (clr),
    .rec_us_act         (act),
    .rec_us_act_fn      (fn),
    .rec_us_act_shift   (sh),
    .rec_act_result     (result),
    .rec_act_valid      (valid),
    .rec_act_ovf        (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest expectation, on time
  always @(negedge clk) begin
    if (rst_n && valid) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid cyc=%0d lane0=%0d lane1=%0d", cyc, result[7:0], result[15:8]);
      end else begin
        exp_t e;
        int   bad;
        e   = sb_q.pop_front();
        bad = -1;
        for (int i = N - 1; i >= 0; i--) if (result[i*NW +: NW] !== e.res[i*NW +: NW]) bad = i;
        if (bad >= 0 || ovf !== e.ovf || cyc != e.at) begin
          mismatched++;
          $display("FAIL act_result cyc=%0d want_cyc=%0d ovf=%0b want_ovf=%0b lane0=%h/%h lane1=%h/%h first_bad_lane=%0d",
                   cyc, e.at, ovf, e.ovf, result[7:0], e.res[7:0], result[15:8], e.res[15:8], bad);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // eca = {en, clr, act}; even lanes use ce/ee, odd lanes co/eo
  task automatic beat(input logic [7:0] ce, input logic [7:0] co, input logic [7:0] op,
                      input logic s, input logic [2:0] eca, input logic [1:0] f,
                      input logic [3:0] shv, input logic push,
                      input logic [7:0] ee, input logic [7:0] eo, input logic eovf);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      coeff[i*NW +: NW]  = (i % 2 == 0) ? ce : co;
      neuron[i*NW +: NW] = op;
      e.res[i*NW +: NW]  = (i % 2 == 0) ? ee : eo;
    end
    sgn = s; {en, clr, act} = eca; fn = f; sh = shv; hold = 1'b0; halt = 1'b0;
    if (push) begin
      e.ovf = eovf;
      e.at  = cyc + 3;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic h, input logic hl, input logic a);
    {en, clr, act} = {a, a, a}; hold = h; halt = hl;
    @(posedge clk); #1;
    hold = 1'b0; halt = 1'b0; {en, clr, act} = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0; coeff = '0; neuron = '0; sgn = 1'b0; hold = 1'b0; halt = 1'b0;
    en = 1'b0; clr = 1'b0; act = 1'b0; fn = 2'd0; sh = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result_zero", int'(|result), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat sums, back to back
    beat(8'd3, 8'hFD, 8'd5, 1'b0, 3'b111, 2'd0, 4'd0, 1'b1, 8'd15, 8'hF1, 1'b0);
    beat(8'd4, 8'd4, 8'd5, 1'b0, 3'b111, 2'd0, 4'd0, 1'b1, 8'd20, 8'd20, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Four beats of -400: ReLU gives 0, identity with shift 4 gives -100
    beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b110, 2'd1, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b100, 2'd1, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b101, 2'd1, 4'd0, 1'b1, 8'd0, 8'd0, 1'b0);
    beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b110, 2'd0, 4'd4, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b100, 2'd0, 4'd4, 1'b0, 8'd0, 8'd0, 1'b0);
    beat(8'hFE, 8'hFE, 8'd200, 1'b0, 3'b101, 2'd0, 4'd4, 1'b1, 8'h9C, 8'h9C, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // +/-300 through ReLU64, ReLU and identity with shift 2
    beat(8'd100, 8'h9C, 8'd3, 1'b0, 3'b111, 2'd2, 4'd0, 1'b1, 8'd64, 8'd0, 1'b0);
    beat(8'd100, 8'h9C, 8'd3, 1'b0, 3'b111, 2'd1, 4'd0, 1'b1, 8'd127, 8'd0, 1'b0);
    beat(8'd100, 8'h9C, 8'd3, 1'b0, 3'b111, 2'd0, 4'd2, 1'b1, 8'd75, 8'hB5, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Saturation: 40 x 32385 pins at 524287 -> (524287+4096)>>>13 = 64, then clr drops ovf
    beat(8'd127, 8'd127, 8'd255, 1'b0, 3'b110, 2'd0, 4'd13, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (38) beat(8'd127, 8'd127, 8'd255, 1'b0, 3'b100, 2'd0, 4'd13, 1'b0, 8'd0, 8'd0, 1'b0);
    beat(8'd127, 8'd127, 8'd255, 1'b0, 3'b101, 2'd0, 4'd13, 1'b1, 8'd64, 8'd64, 1'b1);
    beat(8'd1, 8'd1, 8'd2, 1'b0, 3'b111, 2'd0, 4'd0, 1'b1, 8'd2, 8'd2, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Operand sign: -128*-128 = +16384 -> step 1; -128*128 = -16384 -> step 0
    beat(8'h80, 8'h80, 8'h80, 1'b1, 3'b111, 2'd3, 4'd8, 1'b1, 8'd1, 8'd1, 1'b0);
    beat(8'h80, 8'h80, 8'h80, 1'b0, 3'b111, 2'd3, 4'd8, 1'b1, 8'd0, 8'd0, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Hold for 5 cycles with act beats presented: valid arrives 5 cycles late
    beat(8'd5, 8'd5, 8'd6, 1'b0, 3'b111, 2'd0, 4'd0, 1'b1, 8'd30, 8'd30, 1'b0);
    sb_q[sb_q.size()-1].at = sb_q[sb_q.size()-1].at + 5;
    repeat (5) idle(1'b1, 1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Halt mid-sum flushes result and accumulators; next en-only sum starts from 0
    beat(8'd10, 8'd10, 8'd10, 1'b0, 3'b110, 2'd0, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    beat(8'd10, 8'd10, 8'd10, 1'b0, 3'b100, 2'd0, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    chk("halt_result_zero", int'(|result), 0);
    beat(8'd7, 8'd7, 8'd3, 1'b0, 3'b101, 2'd0, 4'd0, 1'b1, 8'd21, 8'd21, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);

    // Halt one cycle behind an act beat: no valid may appear
    beat(8'd9, 8'd9, 8'd9, 1'b0, 3'b111, 2'd0, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);
    chk("halt_inflight_result_zero", int'(|result), 0);

    // Async reset with an act in flight
    beat(8'd2, 8'd2, 8'd2, 1'b0, 3'b111, 2'd0, 4'd0, 1'b1, 8'd4, 8'd4, 1'b0);
    repeat (4) idle(1'b0, 1'b0, 1'b0);
    beat(8'd11, 8'd11, 8'd11, 1'b0, 3'b111, 2'd0, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_result_zero", int'(|result), 0);
    chk("async_reset_valid", int'(valid), 0);
    chk("async_reset_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) idle(1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
